// File: rtl/switch_direction_conditioner.sv
// Synchronises and debounces a raw switch pin; emits a clean level, press/release pulses and a toggling direction select.
// Latency: an accepted edge is registered DEBOUNCE_CYCLES+2 edges after the pin settles; free-running, no backpressure.
module switch_direction_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic c,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic s,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             s_q, s_d;
    logic             busy_q, busy_d;
    logic             btn_s;

    assign btn_s = sync2_q;

    always_comb begin
        sync1_d         = btn_raw;
        sync2_d         = sync1_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        btn_db_d        = btn_db_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        s_d             = s_q;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    btn_db_d      = 1'b1;
                    press_pulse_d = 1'b1;
                    s_d           = ~s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    btn_db_d        = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy tracks the state being entered so it rises on the same edge as the WAIT state
        busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge c) begin
        if (!reset) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            btn_db_q        <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            s_q             <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            btn_db_q        <= btn_db_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            s_q             <= s_d;
            busy_q          <= busy_d;
        end
    end

    assign btn_db        = btn_db_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign s             = s_q;
    assign busy          = busy_q;

endmodule

// File: doc/switch_direction_conditioner.md
Name: switch_direction_conditioner

Overview:
Conditions the raw slide-switch/push-button input that drives the direction select `s` of up_down_counter. It synchronises the asynchronous pin and debounces it with a 4-state FSM and a stability counter. It emits a clean level, one-cycle press/release pulses, and a direction level `s` that toggles on each debounced press. It sits directly upstream of up_down_counter, in the same clock domain `c`.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles of the synchronised input required to accept a transition (20 ms at 50 MHz); legal range 2 to 2^CNT_W.
- CNT_W, 20, width of the stability counter.

Ports:
- c  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- btn_raw  input  1  raw asynchronous switch/button pin.
- btn_db  output  1  debounced level of btn_raw.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- s  output  1  direction select to up_down_counter; toggles on each accepted press.
- busy  output  1  high while in PRESS_WAIT or RELEASE_WAIT.

Behaviour:
- Reset (reset==0 at a rising edge of c):
  - sync1, sync2, cnt, btn_db, press_pulse, release_pulse, s and busy all go to 0.
  - state goes to IDLE.
  - Reset overrides every other event, including a transition due on that same edge.
- Synchroniser: two flops, sync1 <= btn_raw, then sync2 <= sync1. The FSM uses only sync2 (btn_s).
- All outputs are registered. Pulses are high for exactly one cycle.
- IDLE (btn_db=0): btn_s=1 moves to PRESS_WAIT with cnt<=0. Otherwise stay.
- PRESS_WAIT:
  - btn_s=0 returns to IDLE with no pulse (bounce rejected) and clears cnt.
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 moves to PRESSED, sets btn_db<=1, press_pulse<=1 and s<=~s.
  - Otherwise cnt<=cnt+1.
- PRESSED (btn_db=1): btn_s=0 moves to RELEASE_WAIT with cnt<=0. Otherwise stay.
- RELEASE_WAIT:
  - btn_s=1 returns to PRESSED with no pulse and clears cnt.
  - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 moves to IDLE, sets btn_db<=0 and release_pulse<=1.
  - Otherwise cnt<=cnt+1.
- Latency: btn_raw changes and is held, set up before edge 0.
  - btn_s changes after edge 1.
  - The FSM enters the WAIT state at edge 2.
  - The transition and pulse are registered at edge DEBOUNCE_CYCLES+2.
  - With N=4, the pulse is high between edge 6 and edge 7.
- Counter: it counts only in WAIT states and never wraps. The terminal compare is equality at DEBOUNCE_CYCLES-1, so CNT_W must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- A glitch of any length shorter than DEBOUNCE_CYCLES on the synchronised signal produces no pulse and no change in btn_db or s.
- press_pulse and release_pulse are never high in the same cycle, and never in consecutive cycles (minimum spacing is DEBOUNCE_CYCLES+1).
- Reset mid-operation (PRESS_WAIT or PRESSED) discards the pending event and forces s=0.
  - If btn_raw is still 1 after reset is released, it is debounced as a fresh press.
  - That press_pulse is registered at edge N+2, counting edge 0 as the first edge with reset=1.
- s changes only on an accepted press, so up_down_counter sees at most one direction change per physical press.

Test Plan:
1. reset=0 for 5 cycles with btn_raw=1 → btn_db, press_pulse, release_pulse, s and busy are all 0 at every edge. State is IDLE.
2. N=4, clean press: btn_raw 0→1 before edge 0, held → busy=1 from edge 2; press_pulse=1 only between edges 6 and 7; btn_db=1 from edge 6; s 0→1.
3. N=4, bounce: btn_raw high for 3 cycles then low → press_pulse never asserts; btn_db=0 and s=0 throughout; state returns to IDLE with busy=0.
4. N=4, in PRESSED, btn_raw low for 2 cycles then high → btn_db stays 1 and no release_pulse. Then btn_raw low and held → release_pulse for exactly one cycle 6 edges after the fall; btn_db=0.
5. Two full clean press/release cycles → s goes 0→1→0; exactly 2 press_pulses and 2 release_pulses.
6. reset=0 asserted while in PRESS_WAIT (cnt=2), released with btn_raw=1 held → no pulse during reset. press_pulse is registered at edge 6 after release (N=4); s=1.
